mfp_ahb_ram_slave: RTL

AHB-Lite responder backing a word-organised on-chip RAM for the MIPSfpga core's AHB master port. It decodes and registers each selected address phase, inserts a parameterised number of wait states, performs byte, halfword and word accesses with little-endian lane selection, and returns the two-cycle ERROR response for illegal transfers. It sits behind the system address decoder, which drives HSEL and multiplexes HRDATA, HREADYOUT and HRESP back to the core.

---
 rtl/mfp_ahb_pkg.sv | 48 ++++
 rtl/mfp_ahb_ram_array.sv | 31 +++
 rtl/mfp_ahb_ram_slave.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mfp_ahb_pkg.sv
// Shared AHB-Lite encodings, responder FSM states and transfer decode helpers
// for the MIPSfpga RAM slave.
package mfp_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Legal means naturally aligned and no wider than one word.
  function automatic logic xfer_legal(input logic [2:0] size, input logic [1:0] lsb);
    case (size)
      HSIZE_BYTE: return 1'b1;
      HSIZE_HALF: return ~lsb[0];
      HSIZE_WORD: return (lsb == 2'b00);
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_enables(input logic [2:0] size, input logic [1:0] lsb);
    case (size)
      HSIZE_BYTE: return 4'b0001 << lsb;
      HSIZE_HALF: return lsb[1] ? 4'b1100 : 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mfp_ahb_ram_array.sv
// Single-write, single-read synchronous word RAM with byte write enables,
// shaped so FPGA tools map it onto block RAM.
module mfp_ahb_ram_array #(
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [2**AW];
  logic [31:0] rdata_q;

  // Read-before-write on a same-word collision; the top level forwards.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mfp_ahb_ram_slave.sv
// AHB-Lite responder in front of a word RAM: address-phase register, wait-state
// FSM, two-cycle ERROR response, byte lane writes and write-to-read forwarding.
module mfp_ahb_ram_slave
  import mfp_ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  state_e                  state_q;
  logic [2:0]              cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [2:0]              size_q;
  logic                    write_q;
  logic                    dphase_q;
  logic                    ready_q;
  logic                    resp_q;
  logic                    rd_valid_q;
  logic                    fwd_q;
  logic [3:0]              fwd_be_q;
  logic [31:0]             fwd_data_q;

  logic        take, legal, rd_en, wr_en;
  logic [3:0]  wr_be;
  logic [31:0] ram_rdata;
  logic        unused_haddr;

  // ready_q is high only in IDLE/ERR2, the states that may open a new data phase.
  assign take  = HSEL && HREADY && ready_q &&
                 (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign legal = xfer_legal(HSIZE, HADDR[1:0]);
  assign rd_en = take && legal && !HWRITE;
  assign wr_en = dphase_q && write_q && ready_q;
  assign wr_be = lane_enables(size_q, addr_q[1:0]);
  assign unused_haddr = ^HADDR[31:ADDR_WIDTH];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      addr_q     <= '0;
      size_q     <= 3'd0;
      write_q    <= 1'b0;
      dphase_q   <= 1'b0;
      ready_q    <= 1'b1;
      resp_q     <= HRESP_OKAY;
      rd_valid_q <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_be_q   <= 4'd0;
      fwd_data_q <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ERR2: begin
          if (take) begin
            addr_q  <= HADDR[ADDR_WIDTH-1:0];
            size_q  <= HSIZE;
            write_q <= HWRITE;
            if (legal) begin
              dphase_q <= 1'b1;
              resp_q   <= HRESP_OKAY;
              if (WAIT_STATES > 0) begin
                state_q <= ST_WAIT;
                cnt_q   <= 3'(WAIT_STATES);
                ready_q <= 1'b0;
              end else begin
                state_q <= ST_IDLE;
                ready_q <= 1'b1;
              end
            end else begin
              dphase_q <= 1'b0;
              state_q  <= ST_ERR1;
              ready_q  <= 1'b0;
              resp_q   <= HRESP_ERROR;
            end
          end else begin
            dphase_q <= 1'b0;
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            resp_q   <= HRESP_OKAY;
          end
        end
        ST_WAIT: begin
          if (cnt_q <= 3'd1) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ST_ERR1: begin
          state_q <= ST_ERR2;
          ready_q <= 1'b1;
          resp_q  <= HRESP_ERROR;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          resp_q  <= HRESP_OKAY;
        end
      endcase

      // Snapshot any write committing on the same edge so the read sees its bytes.
      if (rd_en) begin
        rd_valid_q <= 1'b1;
        fwd_q      <= wr_en && (addr_q[ADDR_WIDTH-1:2] == HADDR[ADDR_WIDTH-1:2]);
        fwd_be_q   <= wr_be;
        fwd_data_q <= HWDATA;
      end
    end
  end

  mfp_ahb_ram_array #(
    .AW(ADDR_WIDTH - 2)
  ) u_ram (
    .clk_i   (HCLK),
    .we_i    (wr_en),
    .be_i    (wr_be),
    .waddr_i (addr_q[ADDR_WIDTH-1:2]),
    .wdata_i (HWDATA),
    .re_i    (rd_en),
    .raddr_i (HADDR[ADDR_WIDTH-1:2]),
    .rdata_o (ram_rdata)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign HRDATA[gi*8 +: 8] = !rd_valid_q               ? 8'h00 :
                               (fwd_q && fwd_be_q[gi])   ? fwd_data_q[gi*8 +: 8] :
                                                           ram_rdata[gi*8 +: 8];
  end

  assign HREADYOUT = ready_q;
  assign HRESP     = resp_q;

endmodule
